// File: rtl/hart_state_table_if.sv
// hart_state_table_if
// Groups the hart lifecycle request inputs and the state/PC outputs of the
// hart state table into one bundle.
//   master : drives start/kill/prim_set/suspend/resume/PC-write requests and
//            the one-hot issue select; observes the state outputs.
//   slave  : the hart state table itself.
interface hart_state_table_if;
    logic        hstart;
    logic [1:0]  hstart_id;
    logic [31:0] hstart_pc;
    logic        hkill;
    logic [1:0]  hkill_id;
    logic        prim_set;
    logic [1:0]  prim_set_id;
    logic        hsusp;
    logic [1:0]  hsusp_id;
    logic        hresm;
    logic [1:0]  hresm_id;
    logic        pc_we;
    logic [1:0]  pc_wr_id;
    logic [31:0] pc_wr_data;
    logic [3:0]  hart_issue_hstate;
    logic [3:0]  acti_hstate;
    logic [3:0]  prim_hstate;
    logic [31:0] if_pc;
    logic        if_valid;
    logic        hreq_ack;
    logic        hreq_err;

    modport master (
        output hstart, hstart_id, hstart_pc, hkill, hkill_id,
               prim_set, prim_set_id, hsusp, hsusp_id, hresm, hresm_id,
               pc_we, pc_wr_id, pc_wr_data, hart_issue_hstate,
        input  acti_hstate, prim_hstate, if_pc, if_valid, hreq_ack, hreq_err
    );

    modport slave (
        input  hstart, hstart_id, hstart_pc, hkill, hkill_id,
               prim_set, prim_set_id, hsusp, hsusp_id, hresm, hresm_id,
               pc_we, pc_wr_id, pc_wr_data, hart_issue_hstate,
        output acti_hstate, prim_hstate, if_pc, if_valid, hreq_ack, hreq_err
    );
endinterface

// File: rtl/hart_state_table.sv
// hart_state_table
// Per-hart lifecycle state (IDLE / ACTIVE / SUSP), one-hot primary-hart mask
// and resume-PC table for the 4-hart interleaved core.
// Ports:
//   clk  : core clock
//   rst  : asynchronous active-high reset
//   hs   : hart_state_table_if.slave
//          requests  - hstart/hkill/prim_set (ack/err accounted), hsusp/hresm,
//                      pc_we, hart_issue_hstate (one-hot issue select)
//          outputs   - acti_hstate, prim_hstate (registered),
//                      if_pc/if_valid (combinational read),
//                      hreq_ack/hreq_err (registered 1-cycle pulses)
module hart_state_table #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input logic              clk,
    input logic              rst,
    hart_state_table_if.slave hs
);

    typedef enum logic [1:0] {
        HS_IDLE   = 2'd0,
        HS_ACTIVE = 2'd1,
        HS_SUSP   = 2'd2
    } hstate_e;

    hstate_e     state_q [4];
    hstate_e     state_d [4];
    logic [31:0] pc_q [4];
    logic [31:0] pc_d [4];
    logic [3:0]  prim_q, prim_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;

    logic [2:0]  busy_cnt;
    logic        kill_ok;
    logic        start_ok;
    logic        prim_ok;
    logic        resm_hit;
    logic        susp_hit;
    logic        fb_found;
    logic [3:0]  acti;

    // Request arbitration. Only the highest-priority request present among
    // kill > start > prim_set is considered; anything below it is dropped
    // with err, even when the winner itself is rejected.
    always_comb begin
        busy_cnt = '0;
        for (int i = 0; i < 4; i++) begin
            busy_cnt = busy_cnt + {2'b00, (state_q[i] != HS_IDLE)};
        end
        kill_ok  = hs.hkill && (state_q[hs.hkill_id] != HS_IDLE) && (busy_cnt >= 3'd2);
        start_ok = hs.hstart && !hs.hkill && (state_q[hs.hstart_id] == HS_IDLE);
        prim_ok  = hs.prim_set && !hs.hkill && !hs.hstart &&
                   (state_q[hs.prim_set_id] != HS_IDLE);
        ack_d    = kill_ok || start_ok || prim_ok;
        err_d    = (hs.hkill && !kill_ok) || (hs.hstart && !start_ok) ||
                   (hs.prim_set && !prim_ok);
    end

    // Per-hart next state and PC. Kill beats suspend/resume beats start;
    // a resume on the same hart as a suspend wins. Start only targets IDLE
    // harts and pc_we only non-IDLE ones, so they never collide.
    always_comb begin
        resm_hit = 1'b0;
        susp_hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            pc_d[i]    = pc_q[i];
            resm_hit   = hs.hresm && (hs.hresm_id == 2'(i));
            susp_hit   = hs.hsusp && (hs.hsusp_id == 2'(i)) && !resm_hit;
            if (kill_ok && (hs.hkill_id == 2'(i))) begin
                state_d[i] = HS_IDLE;
            end else if (resm_hit && (state_q[i] == HS_SUSP)) begin
                state_d[i] = HS_ACTIVE;
            end else if (susp_hit && (state_q[i] == HS_ACTIVE)) begin
                state_d[i] = HS_SUSP;
            end else if (start_ok && (hs.hstart_id == 2'(i))) begin
                state_d[i] = HS_ACTIVE;
            end
            if (start_ok && (hs.hstart_id == 2'(i))) begin
                pc_d[i] = hs.hstart_pc;
            end else if (hs.pc_we && (hs.pc_wr_id == 2'(i)) && (state_q[i] != HS_IDLE)) begin
                pc_d[i] = hs.pc_wr_data;
            end
        end
    end

    // Primary tracking. Killing the primary hands it to the lowest ACTIVE
    // survivor (after this cycle's suspend/resume), else the lowest SUSP one.
    // An accepted kill guarantees another non-IDLE hart, so a fallback exists.
    always_comb begin
        prim_d   = prim_q;
        fb_found = 1'b0;
        if (prim_ok) begin
            prim_d = 4'b0001 << hs.prim_set_id;
        end else if (kill_ok && prim_q[hs.hkill_id]) begin
            prim_d = '0;
            for (int i = 0; i < 4; i++) begin
                if (!fb_found && (state_d[i] == HS_ACTIVE)) begin
                    prim_d[i] = 1'b1;
                    fb_found  = 1'b1;
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (!fb_found && (state_d[i] == HS_SUSP)) begin
                    prim_d[i] = 1'b1;
                    fb_found  = 1'b1;
                end
            end
        end
    end

    // State, PC and pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= (i == 0) ? HS_ACTIVE : HS_IDLE;
                pc_q[i]    <= (i == 0) ? RESET_VECTOR : 32'h0;
            end
            prim_q <= 4'b0001;
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
                pc_q[i]    <= pc_d[i];
            end
            prim_q <= prim_d;
            ack_q  <= ack_d;
            err_q  <= err_d;
        end
    end

    // Zero-latency fetch-PC read; non-one-hot selects read as 0 / invalid.
    always_comb begin
        acti        = '0;
        hs.if_pc    = '0;
        hs.if_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            acti[i] = (state_q[i] == HS_ACTIVE);
        end
        case (hs.hart_issue_hstate)
            4'b0001: begin hs.if_pc = pc_q[0]; hs.if_valid = acti[0]; end
            4'b0010: begin hs.if_pc = pc_q[1]; hs.if_valid = acti[1]; end
            4'b0100: begin hs.if_pc = pc_q[2]; hs.if_valid = acti[2]; end
            4'b1000: begin hs.if_pc = pc_q[3]; hs.if_valid = acti[3]; end
            default: begin hs.if_pc = '0;      hs.if_valid = 1'b0;    end
        endcase
    end

    assign hs.acti_hstate = acti;
    assign hs.prim_hstate = prim_q;
    assign hs.hreq_ack    = ack_q;
    assign hs.hreq_err    = err_q;

endmodule

// File: tb/tb_hart_state_table.sv
// tb_hart_state_table
// Directed walk through the hart lifecycle scenarios followed by randomized
// requests. Registered outputs are compared by a scoreboard monitor against
// a request-level reference model; the combinational fetch-PC read is
// compared when each request is driven.
module tb_hart_state_table;

    localparam logic [31:0] RV = 32'h0000_1000;

    typedef struct {
        bit          start;
        logic [1:0]  sid;
        logic [31:0] spc;
        bit          kill;
        logic [1:0]  kid;
        bit          pset;
        logic [1:0]  pid;
        bit          susp;
        logic [1:0]  uid;
        bit          resm;
        logic [1:0]  rid;
        bit          we;
        logic [1:0]  wid;
        logic [31:0] wdata;
        logic [3:0]  issue;
    } req_t;

    typedef struct {
        logic [3:0] acti;
        logic [3:0] prim;
        logic       ack;
        logic       err;
    } exp_t;

    logic clk;
    logic rst;
    hart_state_table_if bus ();

    hart_state_table #(.RESET_VECTOR(RV)) dut (
        .clk (clk),
        .rst (rst),
        .hs  (bus)
    );

    int checks   = 0;
    int failures = 0;
    exp_t sbq[$];

    // Reference model: 0 = idle, 1 = active, 2 = suspended
    int          mst [4];
    int          mprim;
    logic [31:0] mpc [4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic req_t noReq();
        req_t r;
        r.start = 0; r.sid = 0; r.spc = 0;
        r.kill  = 0; r.kid = 0;
        r.pset  = 0; r.pid = 0;
        r.susp  = 0; r.uid = 0;
        r.resm  = 0; r.rid = 0;
        r.we    = 0; r.wid = 0; r.wdata = 0;
        r.issue = 0;
        return r;
    endfunction

    function automatic req_t randReq();
        req_t r = noReq();
        r.start = ($urandom_range(3) == 0);
        r.sid   = 2'($urandom_range(3));
        r.spc   = $urandom;
        r.kill  = ($urandom_range(5) == 0);
        r.kid   = 2'($urandom_range(3));
        r.pset  = ($urandom_range(4) == 0);
        r.pid   = 2'($urandom_range(3));
        r.susp  = ($urandom_range(3) == 0);
        r.uid   = 2'($urandom_range(3));
        r.resm  = ($urandom_range(3) == 0);
        r.rid   = 2'($urandom_range(3));
        r.we    = ($urandom_range(2) == 0);
        r.wid   = 2'($urandom_range(3));
        r.wdata = $urandom;
        if ($urandom_range(1) == 1) r.issue = 4'b0001 << $urandom_range(3);
        else                        r.issue = 4'($urandom);
        return r;
    endfunction

    task automatic driveBus(input req_t r);
        bus.hstart            = r.start;
        bus.hstart_id         = r.sid;
        bus.hstart_pc         = r.spc;
        bus.hkill             = r.kill;
        bus.hkill_id          = r.kid;
        bus.prim_set          = r.pset;
        bus.prim_set_id       = r.pid;
        bus.hsusp             = r.susp;
        bus.hsusp_id          = r.uid;
        bus.hresm             = r.resm;
        bus.hresm_id          = r.rid;
        bus.pc_we             = r.we;
        bus.pc_wr_id          = r.wid;
        bus.pc_wr_data        = r.wdata;
        bus.hart_issue_hstate = r.issue;
    endtask

    task automatic modelReset();
        for (int i = 0; i < 4; i++) begin
            mst[i] = (i == 0) ? 1 : 0;
            mpc[i] = (i == 0) ? RV : 32'h0;
        end
        mprim = 0;
        sbq.delete();
    endtask

    // One clock of the lifecycle rules applied request by request.
    task automatic modelStep(input req_t r, output exp_t e);
        int busy = 0;
        int nst [4];
        bit ack = 0;
        bit err = 0;
        for (int i = 0; i < 4; i++) begin
            if (mst[i] != 0) busy++;
            nst[i] = mst[i];
        end
        if (r.we && mst[r.wid] != 0) mpc[r.wid] = r.wdata;
        if (r.resm && mst[r.rid] == 2) nst[r.rid] = 1;
        if (r.susp && !(r.resm && r.rid == r.uid) && mst[r.uid] == 1) nst[r.uid] = 2;
        if (r.kill) begin
            if (mst[r.kid] != 0 && busy >= 2) begin
                ack = 1;
                nst[r.kid] = 0;
                if (mprim == int'(r.kid)) begin
                    mprim = -1;
                    for (int i = 0; i < 4; i++) if (mprim < 0 && nst[i] == 1) mprim = i;
                    for (int i = 0; i < 4; i++) if (mprim < 0 && nst[i] == 2) mprim = i;
                end
            end else begin
                err = 1;
            end
            if (r.start || r.pset) err = 1;
        end else if (r.start) begin
            if (mst[r.sid] == 0) begin
                ack = 1;
                nst[r.sid] = 1;
                mpc[r.sid] = r.spc;
            end else begin
                err = 1;
            end
            if (r.pset) err = 1;
        end else if (r.pset) begin
            if (mst[r.pid] != 0) begin
                ack = 1;
                mprim = r.pid;
            end else begin
                err = 1;
            end
        end
        for (int i = 0; i < 4; i++) begin
            mst[i] = nst[i];
            e.acti[i] = (nst[i] == 1);
        end
        e.prim = 4'b0001 << mprim;
        e.ack  = ack;
        e.err  = err;
    endtask

    task automatic applyStimulus(input req_t r);
        exp_t e;
        logic [31:0] epc;
        logic        ev;
        @(negedge clk);
        driveBus(r);
        #1;
        epc = 0;
        ev  = 0;
        if ($onehot(r.issue)) begin
            for (int i = 0; i < 4; i++) begin
                if (r.issue[i]) begin
                    epc = mpc[i];
                    ev  = (mst[i] == 1);
                end
            end
        end
        checkOutput("if_pc", bus.if_pc, epc);
        checkOutput("if_valid", {31'b0, bus.if_valid}, {31'b0, ev});
        modelStep(r, e);
        sbq.push_back(e);
        @(posedge clk);
        #2;
        driveBus(noReq());
    endtask

    // Scoreboard monitor: registered outputs appear one cycle after a request.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!rst && sbq.size() > 0) begin
            e = sbq.pop_front();
            checkOutput("acti_hstate", {28'b0, bus.acti_hstate}, {28'b0, e.acti});
            checkOutput("prim_hstate", {28'b0, bus.prim_hstate}, {28'b0, e.prim});
            checkOutput("hreq_ack", {31'b0, bus.hreq_ack}, {31'b0, e.ack});
            checkOutput("hreq_err", {31'b0, bus.hreq_err}, {31'b0, e.err});
        end
    end

    // Asserts reset between edges while a request is on the bus and checks
    // that every output returns to its reset value without a clock edge.
    task automatic resetMid();
        req_t r = noReq();
        r.start = 1; r.sid = 3; r.spc = 32'hDEAD_0000;
        r.issue = 4'b0001;
        @(negedge clk);
        driveBus(r);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_acti", {28'b0, bus.acti_hstate}, 32'h1);
        checkOutput("rst_prim", {28'b0, bus.prim_hstate}, 32'h1);
        checkOutput("rst_ack", {31'b0, bus.hreq_ack}, 32'h0);
        checkOutput("rst_err", {31'b0, bus.hreq_err}, 32'h0);
        checkOutput("rst_if_pc", bus.if_pc, RV);
        checkOutput("rst_if_valid", {31'b0, bus.if_valid}, 32'h1);
        @(posedge clk);
        #1;
        checkOutput("rst_hold_acti", {28'b0, bus.acti_hstate}, 32'h1);
        @(negedge clk);
        driveBus(noReq());
        rst = 1'b0;
        modelReset();
    endtask

    initial begin
        req_t r;
        rst = 1'b1;
        driveBus(noReq());
        modelReset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("init_acti", {28'b0, bus.acti_hstate}, 32'h1);
        checkOutput("init_prim", {28'b0, bus.prim_hstate}, 32'h1);
        checkOutput("init_ack", {31'b0, bus.hreq_ack}, 32'h0);
        checkOutput("init_err", {31'b0, bus.hreq_err}, 32'h0);

        r = noReq(); r.issue = 4'b0001; applyStimulus(r);
        r = noReq(); r.issue = 4'b0010; applyStimulus(r);
        // start hart 2, then read it back and repeat the start (err)
        r = noReq(); r.start = 1; r.sid = 2; r.spc = 32'h100; applyStimulus(r);
        r = noReq(); r.start = 1; r.sid = 2; r.spc = 32'h300; r.issue = 4'b0100; applyStimulus(r);
        // bring up hart 1, kill the primary chain down to hart 2
        r = noReq(); r.start = 1; r.sid = 1; r.spc = 32'h200; applyStimulus(r);
        r = noReq(); r.kill = 1; r.kid = 0; applyStimulus(r);
        r = noReq(); r.kill = 1; r.kid = 1; applyStimulus(r);
        r = noReq(); r.kill = 1; r.kid = 2; applyStimulus(r);
        // suspend / resume interplay
        r = noReq(); r.start = 1; r.sid = 1; r.spc = 32'h240; applyStimulus(r);
        r = noReq(); r.susp = 1; r.uid = 1; applyStimulus(r);
        r = noReq(); r.susp = 1; r.uid = 1; r.resm = 1; r.rid = 1; r.issue = 4'b0010; applyStimulus(r);
        r = noReq(); r.susp = 1; r.uid = 1; r.issue = 4'b0010; applyStimulus(r);
        r = noReq(); r.kill = 1; r.kid = 2; r.issue = 4'b0010; applyStimulus(r);
        r = noReq(); r.resm = 1; r.rid = 1; applyStimulus(r);
        // same-cycle conflicts
        r = noReq(); r.start = 1; r.sid = 3; r.kill = 1; r.kid = 3; applyStimulus(r);
        r = noReq(); r.start = 1; r.sid = 2; r.spc = 32'h500; applyStimulus(r);
        r = noReq(); r.kill = 1; r.kid = 1; r.pset = 1; r.pid = 2; applyStimulus(r);
        r = noReq(); r.pset = 1; r.pid = 0; applyStimulus(r);
        r = noReq(); r.pset = 1; r.pid = 2; r.issue = 4'b0100; applyStimulus(r);
        // PC write to an IDLE hart is dropped, to an ACTIVE hart lands next cycle
        r = noReq(); r.we = 1; r.wid = 3; r.wdata = 32'hBAD0_0003; applyStimulus(r);
        r = noReq(); r.we = 1; r.wid = 2; r.wdata = 32'h0000_0777; r.issue = 4'b1000; applyStimulus(r);
        r = noReq(); r.issue = 4'b0100; applyStimulus(r);
        r = noReq(); r.issue = 4'b0110; applyStimulus(r);

        resetMid();

        for (int n = 0; n < 500; n++) begin
            applyStimulus(randReq());
            if (n == 250) resetMid();
        end

        repeat (2) @(negedge clk);
        checkOutput("scoreboard_drained", sbq.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hart_state_table.md
# hart_state_table

Hart state table unit for the 4-hart interleaved core. Holds the per-hart lifecycle state (idle / active / suspended), the one-hot primary-hart mask and the per-hart resume PC. It produces `acti_hstate` and `prim_hstate` for the hart switch unit. It consumes the switch's one-hot `hart_issue_hstate` to return the fetch PC of the selected hart.

## Interface
Parameters:
- RESET_VECTOR, 32'h0000_0000, PC loaded into hart 0 on reset.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset, asynchronous, active-high.
- hstart  in  1  request to start a hart.
- hstart_id  in  2  target hart of hstart.
- hstart_pc  in  32  start PC for hstart.
- hkill  in  1  request to kill a hart.
- hkill_id  in  2  target hart of hkill.
- prim_set  in  1  request to move primary status.
- prim_set_id  in  2  new primary hart.
- hsusp  in  1  suspend a hart (cache miss).
- hsusp_id  in  2  hart to suspend.
- hresm  in  1  resume a hart (miss refill done).
- hresm_id  in  2  hart to resume.
- pc_we  in  1  PC table write enable.
- pc_wr_id  in  2  PC table write hart.
- pc_wr_data  in  32  PC table write data.
- hart_issue_hstate  in  4  one-hot issue select from the hart switch.
- acti_hstate  out  4  bit i = hart i ACTIVE (registered).
- prim_hstate  out  4  one-hot primary hart (registered).
- if_pc  out  32  PC of the issued hart (combinational).
- if_valid  out  1  issue select is one-hot and the selected hart is ACTIVE.
- hreq_ack  out  1  pulse: the previous cycle's start/kill/prim_set was accepted.
- hreq_err  out  1  pulse: the previous cycle's start/kill/prim_set was rejected.

## Operation
- Per-hart 2-bit state: IDLE, ACTIVE, SUSP. `acti_hstate[i]` = (state[i]==ACTIVE).
- Reset values:
  - hart 0 ACTIVE, harts 1-3 IDLE.
  - prim_hstate = 4'b0001, acti_hstate = 4'b0001.
  - pc[0] = RESET_VECTOR, pc[1..3] = 0.
  - hreq_ack = hreq_err = 0.
- Start:
  - Target IDLE: goes to ACTIVE and pc[id] <= hstart_pc; ack.
  - Target not IDLE: no change; err.
- Kill:
  - Target not IDLE and at least one other hart not IDLE: target goes to IDLE; ack.
  - Target IDLE, or target is the only non-IDLE hart: no change; err.
- Kill of the primary: primary moves to the lowest-numbered remaining ACTIVE hart. If none is ACTIVE, it moves to the lowest-numbered SUSP hart. prim_hstate is never 0 and never has more than one bit set.
- prim_set:
  - Target not IDLE: prim_hstate <= one-hot(id); ack.
  - Target IDLE: err.
- Suspend: ACTIVE goes to SUSP. Resume: SUSP goes to ACTIVE. Any other state: ignored, no ack/err.
- Same-cycle priority:
  - On one hart: kill > suspend/resume > start.
  - A start losing to a same-id kill reports err.
  - hsusp and hresm on the same id: resume wins.
- Requests on different harts in the same cycle all take effect.
- ack/err accounting: at most one of start/kill/prim_set is accepted per cycle, with priority kill > start > prim_set. Lower-priority requests in that cycle are dropped and report err. hreq_ack and hreq_err may both be 1 in the same cycle.
- prim_set combined with a kill of prim_set_id in the same cycle: kill wins, prim_set gets err, and the fallback primary rule applies.
- PC table:
  - pc_we writes pc[pc_wr_id] when that hart is ACTIVE or SUSP. Writes to IDLE harts are dropped.
  - An accepted hstart to the same id overrides pc_we.
- if_pc:
  - = pc[index(hart_issue_hstate)] when hart_issue_hstate is one-hot, else 0.
  - if_valid = one-hot AND that hart is ACTIVE.

## Timing
- All requests are sampled on posedge clk.
- acti_hstate, prim_hstate and pc[] update at that same edge; the new values are visible in the cycle after the request.
- hreq_ack / hreq_err are 1-cycle registered pulses in the cycle after the request.
- if_pc / if_valid: zero-latency read of the current registers. A pc_we in cycle N is visible on if_pc in cycle N+1 (no write-through).
- rst asserted at any time, including mid-request: all state returns to reset values immediately, and pending pulses clear.

## Test plan
- Reset release: acti=0001, prim=0001, if_pc=RESET_VECTOR with issue=0001, if_valid=1; issue=0010 → if_valid=0.
- hstart id=2 pc=0x100 → next cycle acti=0101, ack=1; then issue=0100 → if_pc=0x100. Repeat start id=2 → err=1, acti unchanged.
- With acti=0111, prim=0001: hkill id=0 → acti=0110, prim=0010, ack=1. Then kill 1 → acti=0100, prim=0100. Then kill 2 → err=1, acti=0100.
- hsusp id=1 → acti bit1=0, and issue=0010 gives if_valid=0. hsusp and hresm on id=1 in the same cycle → hart 1 ACTIVE. Kill the primary while the only other hart is SUSP → prim moves to that SUSP hart.
- Same cycle: hstart id=3 and hkill id=3 (hart 3 IDLE) → err=1, hart 3 IDLE. Same cycle: hkill id=1 and prim_set id=2 → kill ack, prim_set dropped, both pulses 1.
- pc_we id=3 while hart 3 is IDLE → pc[3] unchanged. rst pulse mid-sequence → all outputs return to reset values without waiting for a clock edge.
